// File: rtl/dmem_stream_reader_if.sv
// Command, dmem read-port and output-stream signals of the dmem stream reader.
// The slave modport is the reader itself; master is the surrounding environment.
interface dmem_stream_reader_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  num_words;
    logic              busy;
    logic              done;
    logic              err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    modport master (
        output start, base_addr, num_words, mem_rd, out_ready,
        input  busy, done, err, mem_addr, out_valid, out_data, out_addr, out_last
    );

    modport slave (
        input  start, base_addr, num_words, mem_rd, out_ready,
        output busy, done, err, mem_addr, out_valid, out_data, out_addr, out_last
    );
endinterface

// File: rtl/dmem_stream_reader.sv
// Walks a block of word-aligned dmem addresses and emits each word on a
// valid/ready stream with its byte address and a last flag.
module dmem_stream_reader #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input logic                 clk,
    input logic                 reset,
    dmem_stream_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              err_q, err_d;

    logic cmd_misaligned;
    logic cmd_empty;
    logic xfer;
    logic load_beat;

    assign cmd_misaligned = (bus.base_addr[1:0] != 2'b00);
    assign cmd_empty      = (bus.num_words == '0);
    assign xfer           = out_valid_q & bus.out_ready;
    // mem_addr already points at the next word, so a beat loads in FETCH and
    // on every non-final transfer, giving one word per cycle.
    assign load_beat      = (state_q == FETCH) ||
                            ((state_q == STREAM) && xfer && !out_last_q);

    // NOTE: sequential state uses <= so every register updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start && !cmd_misaligned) state_d = cmd_empty ? DONE : FETCH;
            FETCH:   state_d = STREAM;
            STREAM:  if (xfer && out_last_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = (state_q == DONE);
    end

    always_comb begin
        // NOTE: each _d defaults to its hold value first, so no branch can infer a latch.
        mem_addr_d  = mem_addr_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;

        if ((state_q == IDLE) && bus.start) begin
            if (cmd_misaligned) begin
                err_d = 1'b1;
            end else if (!cmd_empty) begin
                mem_addr_d  = bus.base_addr;
                remaining_d = bus.num_words;
            end
        end

        if (load_beat) begin
            out_data_d  = bus.mem_rd;
            out_addr_d  = mem_addr_q;
            out_last_d  = (remaining_q == LEN_W'(1));
            out_valid_d = 1'b1;
            mem_addr_d  = mem_addr_q + ADDR_W'(4);
            remaining_d = remaining_q - LEN_W'(1);
        end else if ((state_q == STREAM) && xfer) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // NOTE: datapath registers are reset as well, because mem_addr and out_* are visible outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q  <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign bus.err       = err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: doc/dmem_stream_reader.md
Name: dmem_stream_reader

Overview:
Sequential read engine for the data memory (`dmem`). On a start command it walks a block of word-aligned addresses on the `dmem` read port, driving `addr0` and sampling `rd0`. Each word is emitted on a valid/ready stream with its address and a last flag. It is the read-side counterpart of the existing write path into `dmem`, and is used for result dumps and DMA-style readback.

Parameters:
ADDR_W, 32, width of memory address and of the out_addr field
DATA_W, 32, memory word width
LEN_W, 16, width of the word-count input

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  command strobe, sampled in IDLE only
base_addr  input  ADDR_W  byte address of first word; must be 4-byte aligned
num_words  input  LEN_W  number of words to read
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse after the final beat is accepted, or after a zero-length command
err  output  1  one-cycle pulse on a misaligned start
mem_addr  output  ADDR_W  to dmem addr0; driven directly from a register
mem_rd  input  DATA_W  from dmem rd0; combinational read of mem_addr
out_valid  output  1  stream beat valid
out_ready  input  1  downstream accept
out_data  output  DATA_W  word read
out_addr  output  ADDR_W  byte address of out_data
out_last  output  1  high on the final beat of the command

Behaviour:
- Reset (edge with reset=1): state=IDLE; busy, done, err, out_valid, out_last = 0; mem_addr, out_data, out_addr = 0; internal remaining count = 0.
- Handshake: a beat transfers at a rising edge where out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_addr and out_last hold stable.
  - out_valid never deasserts without a transfer, except on reset.
- States: IDLE, FETCH, STREAM, DONE.
- IDLE:
  - start=1, base_addr[1:0]!=0: err=1 next cycle; no other effect; stay IDLE.
  - start=1, aligned, num_words==0: go to DONE.
  - start=1, aligned, num_words>0: latch mem_addr=base_addr, remaining=num_words; go to FETCH.
  - start while not IDLE is ignored.
- FETCH (one cycle):
  - out_data<=mem_rd, out_addr<=mem_addr, out_last<=(remaining==1), out_valid<=1.
  - mem_addr<=mem_addr+4, remaining<=remaining-1.
  - Go to STREAM.
- STREAM, on a transfer:
  - out_last=1: out_valid<=0, go to DONE.
  - Otherwise (back-to-back, mem_addr already points to next word): out_data<=mem_rd, out_addr<=mem_addr, out_last<=(remaining==1), mem_addr<=mem_addr+4, remaining<=remaining-1.
  - No transfer: hold all registers.
- DONE (one cycle): done=1, then go to IDLE.
- Latency and throughput:
  - start sampled at edge k: out_valid first high after edge k+1.
  - Sustained rate is 1 word/cycle with out_ready=1.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFFFFFC+4 = 0x00000000, with no error.
- Reset mid-operation: abort immediately to reset values; the partial stream is dropped; no done pulse.

Test Plan:
- Preload dmem[0x64]=0x0000000A; start base=0x64, n=1, ready=1 -> mem_addr=0x64, one beat data=0x0000000A, addr=0x64, last=1; done=1 the cycle after the transfer, busy=0 after that.
- Preload 0x60..0x6C = 1,2,3,4; base=0x60, n=4, ready=1 -> 4 beats on consecutive cycles at addr 0x60/64/68/6C, data 1..4; last only on 4th; exactly one done pulse.
- Same setup, out_ready=0 for 3 cycles while beat 2 is valid -> data=2, addr=0x64 held stable; sequence continues 3,4 with no skipped or duplicated beats.
- n=0 -> done pulse the cycle after start, out_valid never high. base=0x66, n=2 -> err pulse, no beats, busy stays 0.
- base=0xFFFFFFF8, n=3 -> beat addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; no err.
- Assert reset while beat 2 of 4 is valid -> next cycle out_valid=0, busy=0, mem_addr=0, no done. A new start base=0x60, n=1 then completes normally.
